pw_multi_trigger: RTL and testbench
===================================

PW_MULTI_TRIGGER -- requirements
Module: pw_multi_trigger

Interface
REQ-001 Parameters SHALL be: pNUM_PULSES, default 8, maximum pulses per sequence; pDELAY_WIDTH, default 20, delay field bits; pWIDTH_WIDTH, default 17, width field bits; pINDEX_WIDTH, default 4, pulse-count/index bits (2^pINDEX_WIDTH > pNUM_PULSES).
REQ-002 Ports SHALL be, in order:
- trigger_clk, in, 1, sole clock.
- reset_i, in, 1, synchronous active-high reset.
- I_match, in, 1, single-cycle match pulse, already in trigger_clk domain.
- I_delay, in, pNUM_PULSES*pDELAY_WIDTH, delay d[i] at bits [i*pDELAY_WIDTH +: pDELAY_WIDTH].
- I_width, in, pNUM_PULSES*pWIDTH_WIDTH, width w[i] at bits [i*pWIDTH_WIDTH +: pWIDTH_WIDTH].
- I_num_pulses, in, pINDEX_WIDTH, pulses per sequence.
- I_enable, in, 1, global enable.
- I_oneshot, in, 1, 1 = sequence requires arming.
- I_arm, in, 1, arm pulse.
- I_abort, in, 1, abort pulse.
- I_clear, in, 1, clears sticky overrun.
- I_invert, in, 1, output polarity.
- O_trigger, out, 1, trigger output.
- O_busy, out, 1, sequence in progress.
- O_armed, out, 1, armed flag.
- O_pulse_index, out, pINDEX_WIDTH, index of current pulse.
- O_done, out, 1, one-cycle end-of-sequence pulse.
- O_overrun, out, 1, sticky: match ignored while busy.

Function
REQ-003 The FSM SHALL have states IDLE, DELAY and HIGH; O_busy SHALL be 1 in DELAY and HIGH.
REQ-004 In IDLE, a match SHALL be accepted when I_match & I_enable & (~I_oneshot | armed) & (I_num_pulses != 0) & ~I_abort.
REQ-005 On acceptance, all d[i], w[i] and the pulse count SHALL be snapshotted; later input changes SHALL NOT affect the running sequence.
REQ-006 The snapshotted pulse count SHALL be min(I_num_pulses, pNUM_PULSES).
REQ-007 If the match is accepted at edge k, internal trigger trig_r SHALL rise at edge k+1+d[0] and stay high for max(w[0],1) cycles; d[0]=0 gives 1-cycle latency.
REQ-008 For i>0, trig_r SHALL be low for max(d[i],1) cycles after pulse i-1 falls, then high for max(w[i],1) cycles.
REQ-009 O_pulse_index SHALL equal i from the start of pulse i's delay until pulse i ends, and 0 in IDLE.
REQ-010 At the edge where the last pulse falls: state SHALL become IDLE, O_done SHALL be 1 for exactly that cycle, and in oneshot mode armed SHALL clear.
REQ-011 armed SHALL be set by I_arm in any state and cleared by I_abort or on acceptance in oneshot mode; clear SHALL take priority over set on the same edge.
REQ-012 I_match while O_busy=1 SHALL be ignored and SHALL set O_overrun; I_clear SHALL clear it; set SHALL win over a simultaneous clear.
REQ-013 I_abort SHALL force IDLE with trig_r=0 at the next edge, with no O_done; abort SHALL win over a same-cycle match or sequence end.
REQ-014 Deasserting I_enable mid-sequence SHALL NOT stop the sequence; it SHALL only block new acceptances.
REQ-015 O_trigger SHALL be trig_r XOR I_invert; this is the only combinational output path.
REQ-016 Delay/width counters SHALL be max(pDELAY_WIDTH,pWIDTH_WIDTH) bits and SHALL never wrap; all-ones values SHALL give exactly 2^N-1 cycles.

Reset
REQ-017 reset_i SHALL force at the next edge: state IDLE, trig_r=0 (O_trigger=I_invert), O_busy=0, O_armed=0, O_pulse_index=0, O_done=0, O_overrun=0, including mid-sequence.
REQ-018 Snapshot registers SHALL need no reset.

Structure
REQ-019 State encodings and default parameter values SHALL live in shared package pw_trigger_pkg.
REQ-020 Snapshot storage plus the indexed d/w read mux SHALL be sub-module pw_trig_cfg_bank; FSM and counters SHALL be in pw_multi_trigger.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Timing: num=3, d={2,0,4}, w={1,3,0}, match at edge k -> high [k+3,k+4), [k+5,k+8), [k+12,k+13); O_done at k+13.
- Snapshot/clamp: num=15 with pNUM_PULSES=8 -> exactly 8 pulses; changing I_delay mid-sequence has no effect.
- Oneshot: oneshot=1, no arm, match -> no pulse. I_arm then two matches 50 cycles apart -> one sequence; O_armed=0 after acceptance.
- Overrun/abort: match during HIGH -> O_overrun=1, sequence unchanged. I_abort during pulse 1 -> O_trigger low next edge, no O_done. I_clear -> O_overrun=0.
- Reset/edges: reset_i mid-HIGH with I_invert=1 -> O_trigger=1, all status 0 next edge. num=0 -> match ignored. d[0]=2^20-1 -> rise exactly 2^20 edges after match.

Source files
------------

// File: rtl/pw_trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pw_trigger_pkg
// Brief    : Shared state encodings, default parameters and helpers for the
//            multi-pulse trigger sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pw_trigger_pkg;

  localparam int C_DEF_NUM_PULSES  = 8;
  localparam int C_DEF_DELAY_WIDTH = 20;
  localparam int C_DEF_WIDTH_WIDTH = 17;
  localparam int C_DEF_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pw_trig_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : pw_trig_cfg_bank
// Brief    : Snapshot storage for per-pulse delay/width and pulse count, with
//            indexed read muxes for the running sequence.
// Revision : 1.0 - initial release
// ============================================================================
module pw_trig_cfg_bank
  import pw_trigger_pkg::*;
#(
  parameter int pNUM_PULSES  = C_DEF_NUM_PULSES,
  parameter int pDELAY_WIDTH = C_DEF_DELAY_WIDTH,
  parameter int pWIDTH_WIDTH = C_DEF_WIDTH_WIDTH,
  parameter int pINDEX_WIDTH = C_DEF_INDEX_WIDTH
) (
  input  logic                                trigger_clk,
  input  logic                                i_load,
  input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0] i_delay,
  input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] i_width,
  input  logic [pINDEX_WIDTH-1:0]             i_num_pulses,
  input  logic [pINDEX_WIDTH-1:0]             i_delay_idx,
  input  logic [pINDEX_WIDTH-1:0]             i_width_idx,
  output logic [pDELAY_WIDTH-1:0]             o_delay,
  output logic [pWIDTH_WIDTH-1:0]             o_width,
  output logic [pINDEX_WIDTH-1:0]             o_count
);

  localparam logic [pINDEX_WIDTH-1:0] C_MAX_COUNT = pINDEX_WIDTH'(pNUM_PULSES);

  logic [pNUM_PULSES*pDELAY_WIDTH-1:0] r_delay;
  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] r_width;
  logic [pINDEX_WIDTH-1:0]             r_count;

  // Snapshot only; contents are meaningless until the first load.
  always_ff @(posedge trigger_clk) begin
    if (i_load) begin
      r_delay <= i_delay;
      r_width <= i_width;
      r_count <= (i_num_pulses > C_MAX_COUNT) ? C_MAX_COUNT : i_num_pulses;
    end
  end

  // Out-of-range indices read as zero (only happens past the last pulse).
  always_comb begin
    o_delay = '0;
    o_width = '0;
    for (int i = 0; i < pNUM_PULSES; i++) begin
      if (i_delay_idx == pINDEX_WIDTH'(i)) begin
        o_delay = r_delay[i*pDELAY_WIDTH +: pDELAY_WIDTH];
      end
      if (i_width_idx == pINDEX_WIDTH'(i)) begin
        o_width = r_width[i*pWIDTH_WIDTH +: pWIDTH_WIDTH];
      end
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pw_multi_trigger.sv
`default_nettype none
// ============================================================================
// Module   : pw_multi_trigger
// Brief    : Match-triggered sequencer emitting up to pNUM_PULSES programmable
//            delay/width pulses, with arming, abort and overrun reporting.
// Revision : 1.0 - initial release
// ============================================================================
module pw_multi_trigger
  import pw_trigger_pkg::*;
#(
  parameter int pNUM_PULSES  = C_DEF_NUM_PULSES,
  parameter int pDELAY_WIDTH = C_DEF_DELAY_WIDTH,
  parameter int pWIDTH_WIDTH = C_DEF_WIDTH_WIDTH,
  parameter int pINDEX_WIDTH = C_DEF_INDEX_WIDTH
) (
  input  logic                                trigger_clk,
  input  logic                                reset_i,
  input  logic                                I_match,
  input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0] I_delay,
  input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] I_width,
  input  logic [pINDEX_WIDTH-1:0]             I_num_pulses,
  input  logic                                I_enable,
  input  logic                                I_oneshot,
  input  logic                                I_arm,
  input  logic                                I_abort,
  input  logic                                I_clear,
  input  logic                                I_invert,
  output logic                                O_trigger,
  output logic                                O_busy,
  output logic                                O_armed,
  output logic [pINDEX_WIDTH-1:0]             O_pulse_index,
  output logic                                O_done,
  output logic                                O_overrun
);

  localparam int C_CNT_W = max_int(pDELAY_WIDTH, pWIDTH_WIDTH);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [C_CNT_W-1:0]      r_cnt;
  logic [C_CNT_W-1:0]      w_cnt_nxt;
  logic [pINDEX_WIDTH-1:0] r_idx;
  logic [pINDEX_WIDTH-1:0] w_idx_nxt;
  logic [pINDEX_WIDTH-1:0] w_delay_idx;
  logic                    r_trig;
  logic                    w_trig_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    r_armed;
  logic                    r_overrun;

  logic                    w_busy;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_arm_clr;
  logic [pINDEX_WIDTH:0]   w_idx_inc;

  logic [pDELAY_WIDTH-1:0] w_cfg_delay;
  logic [pWIDTH_WIDTH-1:0] w_cfg_width;
  logic [pINDEX_WIDTH-1:0] w_cfg_count;
  logic [C_CNT_W-1:0]      w_first_delay;
  logic [C_CNT_W-1:0]      w_delay_ext;
  logic [C_CNT_W-1:0]      w_width_ext;
  logic [C_CNT_W-1:0]      w_delay_m1;
  logic [C_CNT_W-1:0]      w_width_m1;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = (r_state == ST_IDLE) & I_match & I_enable
                  & (~I_oneshot | r_armed)
                  & (I_num_pulses != '0) & ~I_abort;

  assign w_delay_idx = r_idx + pINDEX_WIDTH'(1);
  assign w_idx_inc   = {1'b0, r_idx} + (pINDEX_WIDTH+1)'(1);
  assign w_last      = (w_idx_inc == {1'b0, w_cfg_count});

  pw_trig_cfg_bank #(
    .pNUM_PULSES  (pNUM_PULSES),
    .pDELAY_WIDTH (pDELAY_WIDTH),
    .pWIDTH_WIDTH (pWIDTH_WIDTH),
    .pINDEX_WIDTH (pINDEX_WIDTH)
  ) u_cfg_bank (
    .trigger_clk  (trigger_clk),
    .i_load       (w_accept),
    .i_delay      (I_delay),
    .i_width      (I_width),
    .i_num_pulses (I_num_pulses),
    .i_delay_idx  (w_delay_idx),
    .i_width_idx  (r_idx),
    .o_delay      (w_cfg_delay),
    .o_width      (w_cfg_width),
    .o_count      (w_cfg_count)
  );

  // The first delay is taken straight from the inputs because the snapshot
  // is only being written on the accepting edge.
  assign w_first_delay = C_CNT_W'(I_delay[pDELAY_WIDTH-1:0]);
  assign w_delay_ext   = C_CNT_W'(w_cfg_delay);
  assign w_width_ext   = C_CNT_W'(w_cfg_width);
  assign w_delay_m1    = (w_delay_ext == '0) ? '0 : (w_delay_ext - C_CNT_W'(1));
  assign w_width_m1    = (w_width_ext == '0) ? '0 : (w_width_ext - C_CNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_trig_nxt  = r_trig;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_trig_nxt = 1'b0;
        w_idx_nxt  = '0;
        if (w_accept) begin
          w_state_nxt = ST_DELAY;
          w_cnt_nxt   = w_first_delay;
        end
      end

      ST_DELAY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_HIGH;
          w_trig_nxt  = 1'b1;
          w_cnt_nxt   = w_width_m1;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (r_cnt == '0) begin
          w_trig_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_DELAY;
            w_idx_nxt   = w_delay_idx;
            w_cnt_nxt   = w_delay_m1;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_trig_nxt  = 1'b0;
        w_idx_nxt   = '0;
      end
    endcase

    // Abort overrides both acceptance and a same-cycle sequence end.
    if (I_abort) begin
      w_state_nxt = ST_IDLE;
      w_trig_nxt  = 1'b0;
      w_idx_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_trig  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_trig  <= w_trig_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign w_arm_clr = I_abort | (I_oneshot & (w_accept | w_done_nxt));

  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      r_armed   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_arm_clr) begin
        r_armed <= 1'b0;
      end else if (I_arm) begin
        r_armed <= 1'b1;
      end
      if (I_match & w_busy) begin
        r_overrun <= 1'b1;
      end else if (I_clear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign O_trigger     = r_trig ^ I_invert;
  assign O_busy        = w_busy;
  assign O_armed       = r_armed;
  assign O_pulse_index = r_idx;
  assign O_done        = r_done;
  assign O_overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pw_multi_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_multi_trigger
// Brief    : Self-checking bench for pw_multi_trigger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pw_multi_trigger;
  import pw_trigger_pkg::*;

  localparam int NP  = C_DEF_NUM_PULSES;
  localparam int DW  = C_DEF_DELAY_WIDTH;
  localparam int WW  = C_DEF_WIDTH_WIDTH;
  localparam int IW  = C_DEF_INDEX_WIDTH;
  // Narrow-field instance keeps the all-ones delay case short.
  localparam int NDW = 12;
  localparam int NWW = 10;

  logic              trigger_clk = 1'b0;
  logic              reset_i     = 1'b1;
  logic              I_match = 1'b0, I_enable = 1'b0, I_oneshot = 1'b0, I_arm = 1'b0;
  logic              I_abort = 1'b0, I_clear = 1'b0, I_invert = 1'b0;
  logic [NP*DW-1:0]  I_delay = '0;
  logic [NP*WW-1:0]  I_width = '0;
  logic [IW-1:0]     I_num_pulses = '0;
  logic              O_trigger, O_busy, O_armed, O_done, O_overrun;
  logic [IW-1:0]     O_pulse_index;

  logic              n_match = 1'b0;
  logic [NP*NDW-1:0] n_delay = '0;
  logic [NP*NWW-1:0] n_width = '0;
  logic              n_trigger, n_busy, n_armed, n_done, n_overrun;
  logic [IW-1:0]     n_idx;

  always #5 trigger_clk = ~trigger_clk;

  pw_multi_trigger dut (
    .trigger_clk(trigger_clk), .reset_i(reset_i), .I_match(I_match),
    .I_delay(I_delay), .I_width(I_width), .I_num_pulses(I_num_pulses),
    .I_enable(I_enable), .I_oneshot(I_oneshot), .I_arm(I_arm), .I_abort(I_abort),
    .I_clear(I_clear), .I_invert(I_invert), .O_trigger(O_trigger), .O_busy(O_busy),
    .O_armed(O_armed), .O_pulse_index(O_pulse_index), .O_done(O_done),
    .O_overrun(O_overrun)
  );

  pw_multi_trigger #(.pDELAY_WIDTH(NDW), .pWIDTH_WIDTH(NWW)) dut_narrow (
    .trigger_clk(trigger_clk), .reset_i(reset_i), .I_match(n_match),
    .I_delay(n_delay), .I_width(n_width), .I_num_pulses(4'd1),
    .I_enable(1'b1), .I_oneshot(1'b0), .I_arm(1'b0), .I_abort(1'b0),
    .I_clear(1'b0), .I_invert(1'b0), .O_trigger(n_trigger), .O_busy(n_busy),
    .O_armed(n_armed), .O_pulse_index(n_idx), .O_done(n_done),
    .O_overrun(n_overrun)
  );

  typedef struct packed {
    logic          trig;
    logic          done;
    logic          busy;
    logic [IW-1:0] idx;
  } exp_t;

  typedef struct {
    int num;
    int d0, d1, d2;
    int w0, w1, w2;
    bit inv;
    int exp_done;
    int exp_high;
  } vec_t;

  exp_t sb[$];
  int   cfg_d[NP];
  int   cfg_w[NP];
  int   cfg_num;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge trigger_clk);
    #1;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NP; i++) begin
      I_delay[i*DW +: DW] = DW'(cfg_d[i]);
      I_width[i*WW +: WW] = WW'(cfg_w[i]);
    end
    I_num_pulses = IW'(cfg_num);
  endtask

  // Expected per-cycle outputs, j = cycles after the accepting edge.
  task automatic push_model(input int abort_at, output int done_j, output int high_cnt);
    int n, t;
    int s[NP];
    int r[NP];
    int f[NP];
    n = (cfg_num > NP) ? NP : cfg_num;
    t = 0;
    for (int i = 0; i < n; i++) begin
      s[i] = t;
      if (i == 0) r[i] = 1 + cfg_d[0];
      else        r[i] = t + ((cfg_d[i] == 0) ? 1 : cfg_d[i]);
      f[i] = r[i] + ((cfg_w[i] == 0) ? 1 : cfg_w[i]);
      t = f[i];
    end
    done_j   = t;
    high_cnt = 0;
    for (int j = 0; j <= t + 2; j++) begin
      exp_t e;
      e = '0;
      if (abort_at < 0 || j <= abort_at) begin
        for (int i = 0; i < n; i++) begin
          if (j >= s[i] && j < f[i]) begin
            e.busy = 1'b1;
            e.idx  = IW'(i);
            e.trig = (j >= r[i]);
          end
        end
        e.done = (j == t);
      end
      if (e.trig) high_cnt++;
      sb.push_back(e);
    end
  endtask

  // pkind: 0 none, 1 change config, 2 match (overrun), 3 abort, 4 drop enable
  task automatic run_seq(input string tag, input bit inv, input int pkind, input int pj,
                         output int dut_done_j, output int dut_high);
    int   done_m, high_m, j;
    exp_t e;
    I_invert = inv;
    apply_cfg();
    tick();
    I_match = 1'b1;
    push_model((pkind == 3) ? pj : -1, done_m, high_m);
    tick();
    I_match    = 1'b0;
    dut_done_j = -1;
    dut_high   = 0;
    j          = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s_trig@%0d", tag, j), int'(O_trigger ^ inv), int'(e.trig));
      check($sformatf("%s_busy@%0d", tag, j), int'(O_busy), int'(e.busy));
      check($sformatf("%s_idx@%0d", tag, j), int'(O_pulse_index), int'(e.idx));
      check($sformatf("%s_done@%0d", tag, j), int'(O_done), int'(e.done));
      if (O_done && dut_done_j < 0) dut_done_j = j;
      if (O_trigger ^ inv) dut_high++;
      I_match = 1'b0;
      I_abort = 1'b0;
      if (j == pj) begin
        case (pkind)
          1: begin
            for (int i = 0; i < NP; i++) I_delay[i*DW +: DW] = DW'(100);
            I_num_pulses = IW'(1);
          end
          2: I_match  = 1'b1;
          3: I_abort  = 1'b1;
          4: I_enable = 1'b0;
          default: ;
        endcase
      end
      tick();
      j++;
    end
    I_match = 1'b0;
    I_abort = 1'b0;
  endtask

  task automatic match_and_watch(input int n, output int seen);
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    seen = 0;
    for (int j = 0; j < n; j++) begin
      if (O_busy || (O_trigger !== I_invert)) seen++;
      tick();
    end
  endtask

  task automatic pulse_arm();
    I_arm = 1'b1;
    tick();
    I_arm = 1'b0;
  endtask

  vec_t vecs[5];
  int   dj, dh, seen, jj, hh;

  initial begin
    vecs[0] = '{3, 2, 0, 4, 1, 3, 0, 1'b0, 13, 5};
    vecs[1] = '{1, 0, 9, 9, 1, 9, 9, 1'b0,  2, 1};
    vecs[2] = '{2, 1, 3, 9, 2, 2, 9, 1'b1,  9, 4};
    vecs[3] = '{3, 0, 0, 0, 0, 0, 0, 1'b0,  6, 3};
    vecs[4] = '{2, 5, 2, 9, 4, 1, 9, 1'b1, 13, 5};

    repeat (3) tick();
    check("rst_trigger", int'(O_trigger), 0);
    check("rst_busy", int'(O_busy), 0);
    check("rst_armed", int'(O_armed), 0);
    check("rst_index", int'(O_pulse_index), 0);
    check("rst_done", int'(O_done), 0);
    check("rst_overrun", int'(O_overrun), 0);
    I_invert = 1'b1;
    #1;
    check("rst_trigger_inv", int'(O_trigger), 1);
    I_invert = 1'b0;
    reset_i  = 1'b0;
    I_enable = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < NP; i++) begin
        cfg_d[i] = 7;
        cfg_w[i] = 7;
      end
      cfg_num  = vecs[v].num;
      cfg_d[0] = vecs[v].d0; cfg_d[1] = vecs[v].d1; cfg_d[2] = vecs[v].d2;
      cfg_w[0] = vecs[v].w0; cfg_w[1] = vecs[v].w1; cfg_w[2] = vecs[v].w2;
      run_seq($sformatf("vec%0d", v), vecs[v].inv, 0, -1, dj, dh);
      check($sformatf("vec%0d_done_cycle", v), dj, vecs[v].exp_done);
      check($sformatf("vec%0d_high_cycles", v), dh, vecs[v].exp_high);
      check($sformatf("vec%0d_no_overrun", v), int'(O_overrun), 0);
    end

    // Clamp to pNUM_PULSES and immunity to mid-sequence input changes
    for (int i = 0; i < NP; i++) begin
      cfg_d[i] = 1;
      cfg_w[i] = 1;
    end
    cfg_num = 15;
    run_seq("clamp", 1'b0, 1, 5, dj, dh);
    check("clamp_pulses", dh, 8);
    check("clamp_done_cycle", dj, 17);

    // Overrun during HIGH, then clear
    for (int i = 0; i < NP; i++) begin
      cfg_d[i] = 7;
      cfg_w[i] = 7;
    end
    cfg_num = 3;
    cfg_d[0] = 2; cfg_d[1] = 0; cfg_d[2] = 4;
    cfg_w[0] = 1; cfg_w[1] = 3; cfg_w[2] = 0;
    run_seq("ovr", 1'b0, 2, 3, dj, dh);
    check("ovr_done_cycle", dj, 13);
    check("ovr_high_cycles", dh, 5);
    check("ovr_sticky", int'(O_overrun), 1);
    I_clear = 1'b1;
    tick();
    I_clear = 1'b0;
    check("ovr_cleared", int'(O_overrun), 0);

    // Abort during pulse 1
    run_seq("abort", 1'b0, 3, 6, dj, dh);
    check("abort_no_done", dj, -1);
    check("abort_high_cycles", dh, 3);

    // Enable dropped mid-sequence does not stop it
    run_seq("en_drop", 1'b0, 4, 2, dj, dh);
    check("en_drop_done_cycle", dj, 13);
    seen = 0;
    match_and_watch(5, seen);
    check("disabled_ignored", seen, 0);
    I_enable = 1'b1;

    // Zero pulse count is ignored
    cfg_num = 0;
    apply_cfg();
    match_and_watch(5, seen);
    check("num0_ignored", seen, 0);

    // Oneshot arming
    I_oneshot = 1'b1;
    cfg_num  = 1;
    cfg_d[0] = 0;
    cfg_w[0] = 1;
    apply_cfg();
    match_and_watch(5, seen);
    check("oneshot_unarmed", seen, 0);
    pulse_arm();
    check("armed_set", int'(O_armed), 1);
    run_seq("oneshot", 1'b0, 0, -1, dj, dh);
    check("oneshot_done_cycle", dj, 2);
    check("oneshot_armed_cleared", int'(O_armed), 0);
    repeat (44) tick();
    match_and_watch(5, seen);
    check("oneshot_second_ignored", seen, 0);
    pulse_arm();
    I_abort = 1'b1;
    tick();
    I_abort = 1'b0;
    check("abort_disarms", int'(O_armed), 0);
    I_arm   = 1'b1;
    I_abort = 1'b1;
    tick();
    I_arm   = 1'b0;
    I_abort = 1'b0;
    check("arm_abort_same_edge", int'(O_armed), 0);
    I_oneshot = 1'b0;

    // Reset mid-HIGH with inverted output
    cfg_num  = 1;
    cfg_d[0] = 0;
    cfg_w[0] = 10;
    apply_cfg();
    I_invert = 1'b1;
    tick();
    pulse_arm();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    check("pre_rst_trigger", int'(O_trigger), 0);
    check("pre_rst_overrun", int'(O_overrun), 1);
    check("pre_rst_armed", int'(O_armed), 1);
    reset_i = 1'b1;
    tick();
    check("midrst_trigger", int'(O_trigger), 1);
    check("midrst_busy", int'(O_busy), 0);
    check("midrst_armed", int'(O_armed), 0);
    check("midrst_index", int'(O_pulse_index), 0);
    check("midrst_done", int'(O_done), 0);
    check("midrst_overrun", int'(O_overrun), 0);
    reset_i  = 1'b0;
    I_invert = 1'b0;

    // All-ones delay and width fields never wrap
    n_delay[NDW-1:0] = {NDW{1'b1}};
    n_width[NWW-1:0] = {NWW{1'b1}};
    tick();
    n_match = 1'b1;
    tick();
    n_match = 1'b0;
    jj = 0;
    while (n_trigger === 1'b0 && jj < 5000) begin
      tick();
      jj++;
    end
    check("allones_delay_rise", jj, 1 << NDW);
    hh = 0;
    while (n_trigger === 1'b1 && hh < 2000) begin
      tick();
      hh++;
    end
    check("allones_width_high", hh, (1 << NWW) - 1);
    check("allones_done", int'(n_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
